dmem_responder: RTL and testbench

Single-port, byte-addressed data-memory responder that serves the pipeline core's MEM-stage loads and stores over a valid/ready request/response interface. It replaces the flat scratchpad array with a proper slave that owns the storage. It performs RV32I sub-word access, meaning byte/half/word lanes, sign or zero extension, and alignment checking. It has a programmable number of wait states and allows one transaction in flight.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_load_align.sv | 28 ++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder and MEM-stage helpers.
// Holds RV32I load/store funct3 codes, the FSM states and lane helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic logic [3:0] lane_mask(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] m;
    unique case (f3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the addressed byte/half of a word and
// sign- or zero-extends it according to the load funct3.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    unique case (funct3)
      F3_B:    rdata = {{24{b[7]}}, b};
      F3_H:    rdata = {{16{h[15]}}, h};
      F3_W:    rdata = word;
      F3_BU:   rdata = {24'd0, b};
      F3_HU:   rdata = {16'd0, h};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Byte-addressed data-memory slave with RV32I sub-word access, alignment
// checks and programmable wait states; one transaction in flight.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] CNT_INIT =
    (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [7:0]  mem [DEPTH_BYTES];

  logic          accept;
  logic [AW-1:0] base;
  logic [31:0]   rd_word;
  logic [31:0]   ld_data;
  logic [31:0]   wlane;
  logic [3:0]    be;
  logic          in_rng, misal, f3_ok, err, do_wr;

  assign accept = req_valid_i & req_ready_o;
  assign base   = req_addr_i[AW-1:0] & ~AW'(3);

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++)
      rd_word[8*i +: 8] = mem[base | AW'(i)];
  end

  mem_load_align u_align (
    .word   (rd_word),
    .off    (req_addr_i[1:0]),
    .funct3 (req_funct3_i),
    .rdata  (ld_data)
  );

  // full-width compare so high addresses never alias into storage
  always_comb begin
    in_rng = req_addr_i < 32'(DEPTH_BYTES);
    misal  = ((req_funct3_i[1:0] == 2'b01) & req_addr_i[0])
           | ((req_funct3_i[1:0] == 2'b10) & (req_addr_i[1:0] != 2'b00));
    if (req_we_i)
      f3_ok = req_funct3_i inside {F3_B, F3_H, F3_W};
    else
      f3_ok = req_funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    err   = ~in_rng | misal | ~f3_ok;
    do_wr = accept & req_we_i & ~err;
    be    = lane_mask(req_funct3_i, req_addr_i[1:0]);
    unique case (req_funct3_i[1:0])
      2'b00:   wlane = {4{req_wdata_i[7:0]}};
      2'b01:   wlane = {2{req_wdata_i[15:0]}};
      default: wlane = req_wdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++)
      if (do_wr && be[i])
        mem[base | AW'(i)] <= wlane[8*i +: 8];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= err;
      rdata_q <= (req_we_i | err) ? 32'd0 : ld_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt <= '0;
    else if (accept)
      cnt <= CNT_INIT;
    else if (state == WAIT && cnt != 4'd0)
      cnt <= cnt - 4'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nx = (LATENCY == 1) ? RESP : WAIT;
      WAIT:
        if (cnt == 4'd0) state_nx = RESP;
      RESP:
        if (rsp_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state == IDLE) & ~rst_i;
    rsp_valid_o = (state == RESP);
    rsp_rdata_o = rdata_q;
    rsp_err_o   = err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY 1 and LATENCY 4.
// Stimulus pushes expected responses; a negedge monitor pops and checks.
module tb_dmem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rv[2], rdy[2], we[2], rspv[2], rspr[2], er[2];
  logic [31:0] addr[2], wd[2], rd[2];
  logic [2:0]  f3[2];

  dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(1)) u1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(rv[0]), .req_ready_o(rdy[0]),
    .req_addr_i(addr[0]), .req_we_i(we[0]),
    .req_funct3_i(f3[0]), .req_wdata_i(wd[0]),
    .rsp_valid_o(rspv[0]), .rsp_ready_i(rspr[0]),
    .rsp_rdata_o(rd[0]), .rsp_err_o(er[0])
  );

  dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(4)) u4 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(rv[1]), .req_ready_o(rdy[1]),
    .req_addr_i(addr[1]), .req_we_i(we[1]),
    .req_funct3_i(f3[1]), .req_wdata_i(wd[1]),
    .rsp_valid_o(rspv[1]), .rsp_ready_i(rspr[1]),
    .rsp_rdata_o(rd[1]), .rsp_err_o(er[1])
  );

  int total = 0;
  int bad   = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (rspv[0] === 1'b1 && rspr[0] === 1'b1) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp0 unexpected: got %h want none", rd[0]);
      end else begin
        e = q0.pop_front();
        chk("rsp0 rdata", rd[0], e[32:1]);
        chk("rsp0 err", 32'(er[0]), 32'(e[0]));
      end
    end
    if (rspv[1] === 1'b1 && rspr[1] === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp1 unexpected: got %h want none", rd[1]);
      end else begin
        e = q1.pop_front();
        chk("rsp1 rdata", rd[1], e[32:1]);
        chk("rsp1 err", 32'(er[1]), 32'(e[0]));
      end
    end
  end

  task automatic xact(input int k, input logic w, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input int hold, input string nm);
    int n;
    int lat;
    logic [31:0] hr;
    logic he, busy;
    n = 0;
    while (rdy[k] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    rspr[k] = (hold == 0);
    rv[k] = 1'b1; we[k] = w; f3[k] = f; addr[k] = a; wd[k] = d;
    if (k == 0) q0.push_back({exp_rd, exp_err});
    else        q1.push_back({exp_rd, exp_err});
    @(posedge clk); #1;
    rv[k] = 1'b0; we[k] = ~w; f3[k] = 3'b111;
    addr[k] = 32'hFFFF_FFFF; wd[k] = 32'h5A5A_5A5A;
    lat = 1; busy = 1'b0;
    while (rspv[k] !== 1'b1 && lat < 50) begin
      busy |= rdy[k];
      @(posedge clk); #1; lat++;
    end
    chk({nm, " latency"}, lat, (k == 0) ? 1 : 4);
    hr = rd[k]; he = er[k];
    for (int j = 0; j < hold; j++) begin
      busy |= rdy[k];
      chk({nm, " hold"}, {rd[k][31:1], rd[k][0] ^ er[k] ^ ~rspv[k]},
          {hr[31:1], hr[0] ^ he});
      @(posedge clk); #1;
    end
    busy |= rdy[k];
    rspr[k] = 1'b1;
    @(posedge clk); #1;
    chk({nm, " idle"}, {29'd0, rdy[k], rspv[k], busy}, 32'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rv[k] = 0; we[k] = 0; rspr[k] = 1; f3[k] = 0;
      addr[k] = 0; wd[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst ready", 32'(rdy[k]), 0);
      chk("rst valid", 32'(rspv[k]), 0);
      chk("rst rdata", rd[k], 0);
      chk("rst err", 32'(er[k]), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst ready0", 32'(rdy[0]), 1);
    chk("post-rst ready1", 32'(rdy[1]), 1);

    xact(0, 1, F3_W,  32'h10, 32'hDEADBEEF, 0, 0, 0, "sw 10");
    xact(0, 0, F3_W,  32'h10, 0, 32'hDEADBEEF, 0, 0, "lw 10");
    xact(0, 1, F3_W,  32'h20, 32'h80FF7F01, 0, 0, 0, "sw 20");
    xact(0, 0, F3_B,  32'h23, 0, 32'hFFFFFF80, 0, 0, "lb 23");
    xact(0, 0, F3_BU, 32'h23, 0, 32'h00000080, 0, 0, "lbu 23");
    xact(0, 0, F3_H,  32'h22, 0, 32'hFFFF80FF, 0, 0, "lh 22");
    xact(0, 0, F3_HU, 32'h20, 0, 32'h00007F01, 0, 0, "lhu 20");
    xact(0, 0, F3_B,  32'h21, 0, 32'h0000007F, 0, 0, "lb 21");
    xact(0, 1, F3_W,  32'h30, 32'h0, 0, 0, 0, "sw 30");
    xact(0, 1, F3_B,  32'h31, 32'hFFFFFFAB, 0, 0, 0, "sb 31");
    xact(0, 1, F3_H,  32'h32, 32'hFFFF1234, 0, 0, 0, "sh 32");
    xact(0, 0, F3_W,  32'h30, 0, 32'h1234AB00, 0, 0, "lw 30");

    xact(0, 0, F3_W,  32'h21, 0, 0, 1, 0, "lw 21 mis");
    xact(0, 1, F3_H,  32'h33, 32'hFFFF, 0, 1, 0, "sh 33 mis");
    xact(0, 0, F3_W,  32'h30, 0, 32'h1234AB00, 0, 0, "lw 30 kept");
    xact(0, 0, F3_W,  32'h400, 0, 0, 1, 0, "lw 400 rng");
    xact(0, 1, F3_W,  32'h410, 32'h11111111, 0, 1, 0, "sw 410 rng");
    xact(0, 0, 3'b011, 32'h10, 0, 0, 1, 0, "ld f3 011");
    xact(0, 1, 3'b011, 32'h10, 32'h22222222, 0, 1, 0, "st f3 011");
    xact(0, 1, F3_BU, 32'h10, 32'h33333333, 0, 1, 0, "st f3 100");
    xact(0, 0, F3_W,  32'h10, 0, 32'hDEADBEEF, 0, 0, "lw 10 kept");
    xact(0, 1, F3_W,  32'h3FC, 32'hA5A5C3C3, 0, 0, 0, "sw 3fc");
    xact(0, 0, F3_HU, 32'h3FE, 0, 32'h0000A5A5, 0, 0, "lhu 3fe");

    xact(1, 1, F3_W,  32'h50, 32'hCAFEF00D, 0, 0, 0, "L4 sw 50");
    xact(1, 0, F3_W,  32'h50, 0, 32'hCAFEF00D, 0, 3, "L4 lw 50 bp");
    xact(1, 0, F3_H,  32'h51, 0, 0, 1, 2, "L4 lh 51 bp");

    while (rdy[1] !== 1'b1) begin @(posedge clk); #1; end
    rv[1] = 1; we[1] = 1; f3[1] = F3_W; addr[1] = 32'h40; wd[1] = 32'h55;
    @(posedge clk); #1;
    rv[1] = 0; we[1] = 0;
    seen = rspv[1];
    @(posedge clk); #1;
    seen |= rspv[1];
    @(posedge clk); #1;
    seen |= rspv[1];
    rst = 1'b1;
    #1;
    seen |= rspv[1];
    repeat (2) @(posedge clk);
    #1;
    seen |= rspv[1];
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= rspv[1];
    end
    chk("rst-wait no rsp", 32'(seen), 0);
    chk("rst-wait ready", 32'(rdy[1]), 1);
    xact(1, 0, F3_W, 32'h40, 0, 32'h00000055, 0, 0, "L4 lw 40");
    xact(0, 0, F3_W, 32'h10, 0, 32'hDEADBEEF, 0, 0, "lw 10 post-rst");

    repeat (2) @(posedge clk);
    chk("q0 drained", 32'(q0.size()), 0);
    chk("q1 drained", 32'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
